// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the out-of-order core back end.
// Holds the ROB entry layout and the small helpers the ROB needs.
package uarch_pkg;

  localparam int ROB_DEPTH_DEFAULT = 32;
  localparam int ROB_TAG_W         = $clog2(ROB_DEPTH_DEFAULT);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic        is_valid;
    logic        is_ready;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        has_rd;
    logic        has_exception;
    logic        is_branch;
    logic        is_jump;
    logic        is_store;
    logic [31:0] result;
  } rob_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  // A freshly dispatched entry is valid, not yet complete, and holds no result.
  function automatic rob_entry_t rob_prep(input rob_entry_t e);
    rob_entry_t r;
    r          = e;
    r.is_valid = 1'b1;
    r.is_ready = 1'b0;
    r.result   = '0;
    return r;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: 2-wide allocate, 2 CDB writeback ports,
// 2-wide in-order commit (max one store per cycle), head-fault reporting.
module reorder_buffer
  import uarch_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       rob_we,
  input  rob_entry_t       rob_entry0,
  input  rob_entry_t       rob_entry1,
  output logic [1:0]       rob_rdy,
  output logic [TAG_W-1:0] alloc_tag0,
  output logic [TAG_W-1:0] alloc_tag1,
  input  logic [1:0]       cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag0,
  input  logic [TAG_W-1:0] cdb_tag1,
  input  logic [31:0]      cdb_result0,
  input  logic [31:0]      cdb_result1,
  input  logic [1:0]       cdb_exc,
  output logic [1:0]       commit_valid,
  output logic [4:0]       commit_rd0,
  output logic [4:0]       commit_rd1,
  output logic [1:0]       commit_has_rd,
  output logic [31:0]      commit_result0,
  output logic [31:0]      commit_result1,
  output logic [1:0]       commit_store,
  output logic             exc_valid,
  output logic [31:0]      exc_pc
);

  localparam logic [TAG_W:0] DEPTH_C  = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [TAG_W:0] DEPTH_M1 = (TAG_W+1)'(ROB_DEPTH - 1);

  rob_entry_t       ent_q [ROB_DEPTH];
  rob_entry_t       ent_d [ROB_DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0] head1, tail1;
  logic [TAG_W:0]   count_q, count_d, free_cnt;
  logic [1:0]       n_we, n_alloc, n_commit;
  logic             alloc_ok;
  rob_entry_t       h0, h1, slot_a, slot_b;

  assign head1 = head_q + TAG_W'(1);
  assign tail1 = tail_q + TAG_W'(1);
  assign h0    = ent_q[head_q];
  assign h1    = ent_q[head1];

  // Status to dispatch comes from registered occupancy only.
  assign rob_rdy    = (count_q == DEPTH_C)  ? 2'b00 :
                      (count_q == DEPTH_M1) ? 2'b01 : 2'b10;
  assign alloc_tag0 = tail_q;
  assign alloc_tag1 = tail1;

  assign commit_valid[0] = h0.is_valid & h0.is_ready & ~h0.has_exception;
  assign commit_valid[1] = commit_valid[0] & h1.is_valid & h1.is_ready &
                           ~h1.has_exception & ~(h0.is_store & h1.is_store);
  assign n_commit        = popcount2(commit_valid);

  assign commit_rd0       = commit_valid[0] ? h0.rd     : '0;
  assign commit_rd1       = commit_valid[1] ? h1.rd     : '0;
  assign commit_result0   = commit_valid[0] ? h0.result : '0;
  assign commit_result1   = commit_valid[1] ? h1.result : '0;
  assign commit_has_rd    = commit_valid & {h1.has_rd, h0.has_rd};
  assign commit_store     = commit_valid & {h1.is_store, h0.is_store};

  assign exc_valid = h0.is_valid & h0.is_ready & h0.has_exception;
  assign exc_pc    = exc_valid ? h0.pc : '0;

  // rob_we is compacted: the lowest set slot always lands at the tail.
  assign slot_a   = rob_we[0] ? rob_entry0 : rob_entry1;
  assign slot_b   = rob_entry1;
  assign n_we     = popcount2(rob_we);
  assign free_cnt = DEPTH_C - count_q;
  assign alloc_ok = (TAG_W+1)'(n_we) <= free_cnt;
  assign n_alloc  = alloc_ok ? n_we : 2'd0;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent_d[i].is_valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_valid[0]) ent_d[head_q].is_valid = 1'b0;
      if (commit_valid[1]) ent_d[head1].is_valid  = 1'b0;
      // Port 1 applied last so it wins a same-tag collision on result.
      if (cdb_valid[0] && ent_q[cdb_tag0].is_valid) begin
        ent_d[cdb_tag0].is_ready      = 1'b1;
        ent_d[cdb_tag0].result        = cdb_result0;
        ent_d[cdb_tag0].has_exception = ent_d[cdb_tag0].has_exception | cdb_exc[0];
      end
      if (cdb_valid[1] && ent_q[cdb_tag1].is_valid) begin
        ent_d[cdb_tag1].is_ready      = 1'b1;
        ent_d[cdb_tag1].result        = cdb_result1;
        ent_d[cdb_tag1].has_exception = ent_d[cdb_tag1].has_exception | cdb_exc[1];
      end
      if (n_alloc != 2'd0) ent_d[tail_q] = rob_prep(slot_a);
      if (n_alloc == 2'd2) ent_d[tail1]  = rob_prep(slot_b);
      head_d  = head_q + TAG_W'(n_commit);
      tail_d  = tail_q + TAG_W'(n_alloc);
      count_d = count_q + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(n_commit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  // Dispatch must never write beyond the advertised free space.
  always_ff @(posedge clk) begin
    assert (rst || flush || alloc_ok)
      else $error("reorder_buffer: allocation exceeds free space");
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer (depth 8): directed scenarios plus a randomized
// run against a queue-based program-order model.
module tb_reorder_buffer;
  import uarch_pkg::*;

  localparam int D  = 8;
  localparam int TW = 3;

  logic clk, rst, flush;
  logic [1:0] rob_we, rob_rdy, cdb_valid, cdb_exc, commit_valid, commit_has_rd, commit_store;
  rob_entry_t rob_entry0, rob_entry1;
  logic [TW-1:0] alloc_tag0, alloc_tag1, cdb_tag0, cdb_tag1;
  logic [31:0] cdb_result0, cdb_result1, commit_result0, commit_result1, exc_pc;
  logic [4:0] commit_rd0, commit_rd1;
  logic exc_valid;

  reorder_buffer #(.ROB_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_we(rob_we),
    .rob_entry0(rob_entry0), .rob_entry1(rob_entry1), .rob_rdy(rob_rdy),
    .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .cdb_valid(cdb_valid), .cdb_tag0(cdb_tag0), .cdb_tag1(cdb_tag1),
    .cdb_result0(cdb_result0), .cdb_result1(cdb_result1), .cdb_exc(cdb_exc),
    .commit_valid(commit_valid), .commit_rd0(commit_rd0), .commit_rd1(commit_rd1),
    .commit_has_rd(commit_has_rd), .commit_result0(commit_result0),
    .commit_result1(commit_result1), .commit_store(commit_store),
    .exc_valid(exc_valid), .exc_pc(exc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program-order model: queue front is the oldest in-flight instruction.
  typedef struct {
    int          tag;
    bit          rdy;
    bit          exc;
    bit          st;
    logic [31:0] res;
    logic [4:0]  rd;
    bit          hrd;
    logic [31:0] pc;
  } m_t;

  m_t mq[$];
  int mtail;
  int nerr, nchk;
  logic [1:0] e_rdy, e_cv;
  logic e_exc;
  rob_entry_t z;

  function automatic rob_entry_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                    input logic hrd, input logic st);
    rob_entry_t e;
    e          = '0;
    e.pc       = pc;
    e.rd       = rd;
    e.has_rd   = hrd;
    e.is_store = st;
    e.is_ready = 1'b1;          // junk the ROB must discard
    e.result   = 32'hDEAD_BEEF;
    return e;
  endfunction

  task automatic model_eval();
    int f;
    f     = D - mq.size();
    e_rdy = (f == 0) ? 2'b00 : (f == 1) ? 2'b01 : 2'b10;
    e_cv  = 2'b00;
    e_exc = 1'b0;
    if (mq.size() >= 1) begin
      if (mq[0].rdy && mq[0].exc) e_exc = 1'b1;
      if (mq[0].rdy && !mq[0].exc) e_cv[0] = 1'b1;
    end
    if (e_cv[0] && mq.size() >= 2) begin
      if (mq[1].rdy && !mq[1].exc && !(mq[0].st && mq[1].st)) e_cv[1] = 1'b1;
    end
  endtask

  task automatic push_model(input rob_entry_t e);
    m_t m;
    m.tag = mtail; m.rdy = 1'b0; m.exc = e.has_exception; m.st = e.is_store;
    m.res = '0; m.rd = e.rd; m.hrd = e.has_rd; m.pc = e.pc;
    mq.push_back(m);
    mtail = (mtail + 1) % D;
  endtask

  // Drive one cycle of inputs (called at negedge) and advance the model.
  task automatic step(input logic [1:0] we, input rob_entry_t a, input rob_entry_t b,
                      input logic [1:0] cv, input int t0, input int t1,
                      input logic [31:0] r0, input logic [31:0] r1,
                      input logic [1:0] ex, input logic fl);
    int ncm;
    rob_we = we; rob_entry0 = a; rob_entry1 = b;
    cdb_valid = cv; cdb_tag0 = TW'(t0); cdb_tag1 = TW'(t1);
    cdb_result0 = r0; cdb_result1 = r1; cdb_exc = ex; flush = fl;
    model_eval();
    if (fl) begin
      mq.delete();
      mtail = 0;
    end else begin
      ncm = int'(e_cv[0]) + int'(e_cv[1]);
      for (int k = 0; k < mq.size(); k++)
        if (cv[0] && mq[k].tag == t0) begin mq[k].rdy = 1; mq[k].res = r0; mq[k].exc |= ex[0]; end
      for (int k = 0; k < mq.size(); k++)
        if (cv[1] && mq[k].tag == t1) begin mq[k].rdy = 1; mq[k].res = r1; mq[k].exc |= ex[1]; end
      repeat (ncm) void'(mq.pop_front());
      if (we[0]) push_model(a);
      if (we[1]) push_model(we[0] ? b : a);
      if (we == 2'b10) begin
        void'(mq.pop_back()); mtail = (mtail + D - 1) % D; push_model(b);
      end
    end
    @(posedge clk);
    @(negedge clk);
    model_eval();
  endtask

  task automatic idle();
    step(2'b00, z, z, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic do_flush();
    step(2'b00, z, z, 2'b00, 0, 0, 0, 0, 2'b00, 1'b1);
  endtask

  task automatic test_reset();
    z = '0;
    rst = 1'b1; flush = 1'b0; rob_we = '0; rob_entry0 = '0; rob_entry1 = '0;
    cdb_valid = '0; cdb_tag0 = '0; cdb_tag1 = '0; cdb_result0 = '0; cdb_result1 = '0; cdb_exc = '0;
    #12;
    nchk++; if (rob_rdy !== 2'b10) begin nerr++; $display("FAIL reset_rdy got=%b exp=10", rob_rdy); end
    nchk++; if (alloc_tag0 !== 3'd0 || alloc_tag1 !== 3'd1) begin nerr++; $display("FAIL reset_tags got=%0d/%0d exp=0/1", alloc_tag0, alloc_tag1); end
    nchk++; if (commit_valid !== 2'b00 || exc_valid !== 1'b0) begin nerr++; $display("FAIL reset_commit got=%b/%b exp=00/0", commit_valid, exc_valid); end
    nchk++; if (exc_pc !== 32'd0 || commit_result0 !== 32'd0 || commit_store !== 2'b00) begin nerr++; $display("FAIL reset_zero got pc=%h res=%h st=%b", exc_pc, commit_result0, commit_store); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); mtail = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      step(2'b11, mk(32'h100 + i*8, 5'(i), 1, 0), mk(32'h104 + i*8, 5'(i+8), 1, 0), 0, 0, 0, 0, 0, 0, 0);
      nchk++; if (rob_rdy !== ((i == 3) ? 2'b00 : 2'b10)) begin nerr++; $display("FAIL fill_rdy%0d got=%b", i, rob_rdy); end
      nchk++; if (alloc_tag0 !== 3'((2*i + 2) % D)) begin nerr++; $display("FAIL fill_tag%0d got=%0d exp=%0d", i, alloc_tag0, (2*i+2)%D); end
    end
    idle();
    nchk++; if (rob_rdy !== 2'b00 || commit_valid !== 2'b00) begin nerr++; $display("FAIL full_hold got rdy=%b cv=%b exp=00/00", rob_rdy, commit_valid); end
    do_flush();
    nchk++; if (rob_rdy !== 2'b10 || alloc_tag0 !== 3'd0) begin nerr++; $display("FAIL flush_clear got rdy=%b tag=%0d", rob_rdy, alloc_tag0); end
    for (int i = 0; i < 3; i++) step(2'b11, mk(0, 1, 1, 0), mk(0, 2, 1, 0), 0, 0, 0, 0, 0, 0, 0);
    step(2'b01, mk(0, 3, 1, 0), z, 0, 0, 0, 0, 0, 0, 0);
    nchk++; if (rob_rdy !== 2'b01) begin nerr++; $display("FAIL one_free got=%b exp=01", rob_rdy); end
    do_flush();
  endtask

  task automatic test_ooo_commit();
    step(2'b11, mk(32'h200, 5'd3, 1, 0), mk(32'h204, 5'd4, 1, 0), 0, 0, 0, 0, 0, 0, 0);
    step(2'b00, z, z, 2'b10, 0, 1, 0, 32'h11, 0, 0);
    nchk++; if (commit_valid !== 2'b00) begin nerr++; $display("FAIL ooo_wait got=%b exp=00", commit_valid); end
    step(2'b00, z, z, 2'b01, 0, 0, 32'h22, 0, 0, 0);
    nchk++; if (commit_valid !== 2'b11) begin nerr++; $display("FAIL ooo_cv got=%b exp=11", commit_valid); end
    nchk++; if (commit_result0 !== 32'h22 || commit_result1 !== 32'h11) begin nerr++; $display("FAIL ooo_res got=%h/%h exp=22/11", commit_result0, commit_result1); end
    nchk++; if (commit_rd0 !== 5'd3 || commit_rd1 !== 5'd4 || commit_has_rd !== 2'b11) begin nerr++; $display("FAIL ooo_rd got=%0d/%0d hrd=%b", commit_rd0, commit_rd1, commit_has_rd); end
    idle();
    nchk++; if (commit_valid !== 2'b00 || rob_rdy !== 2'b10) begin nerr++; $display("FAIL ooo_after got cv=%b rdy=%b", commit_valid, rob_rdy); end
  endtask

  task automatic test_stores();
    step(2'b11, mk(32'h300, 5'd5, 0, 1), mk(32'h304, 5'd6, 0, 1), 0, 0, 0, 0, 0, 0, 0);
    step(2'b00, z, z, 2'b11, 2, 3, 32'h5, 32'h6, 0, 0);
    nchk++; if (commit_valid !== 2'b01 || commit_store !== 2'b01 || commit_rd0 !== 5'd5) begin nerr++; $display("FAIL st_first got cv=%b st=%b rd=%0d", commit_valid, commit_store, commit_rd0); end
    idle();
    nchk++; if (commit_valid !== 2'b01 || commit_store !== 2'b01 || commit_rd0 !== 5'd6) begin nerr++; $display("FAIL st_second got cv=%b st=%b rd=%0d", commit_valid, commit_store, commit_rd0); end
    idle();
    nchk++; if (commit_valid !== 2'b00) begin nerr++; $display("FAIL st_done got=%b exp=00", commit_valid); end
  endtask

  task automatic test_exception();
    step(2'b11, mk(32'h80, 5'd7, 1, 0), mk(32'h84, 5'd8, 1, 0), 0, 0, 0, 0, 0, 0, 0);
    step(2'b00, z, z, 2'b11, 4, 5, 32'h1, 32'h2, 2'b01, 0);
    nchk++; if (exc_valid !== 1'b1 || exc_pc !== 32'h80) begin nerr++; $display("FAIL exc_raise got v=%b pc=%h exp=1/80", exc_valid, exc_pc); end
    nchk++; if (commit_valid !== 2'b00) begin nerr++; $display("FAIL exc_nocommit got=%b exp=00", commit_valid); end
    idle();
    nchk++; if (exc_valid !== 1'b1 || commit_valid !== 2'b00) begin nerr++; $display("FAIL exc_hold got v=%b cv=%b", exc_valid, commit_valid); end
    do_flush();
    nchk++; if (exc_valid !== 1'b0 || rob_rdy !== 2'b10 || alloc_tag0 !== 3'd0 || commit_valid !== 2'b00) begin nerr++; $display("FAIL exc_flush got v=%b rdy=%b tag=%0d cv=%b", exc_valid, rob_rdy, alloc_tag0, commit_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(2'b11, mk(0, 1, 1, 0), mk(0, 2, 1, 0), 0, 0, 0, 0, 0, 0, 0);
    step(2'b01, mk(0, 3, 1, 0), z, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(2'b00, z, z, 2'b11, 2*i, 2*i+1, 0, 0, 0, 0);
    step(2'b00, z, z, 2'b01, 6, 0, 0, 0, 0, 0);
    idle(); idle();
    nchk++; if (alloc_tag0 !== 3'd7 || alloc_tag1 !== 3'd0 || rob_rdy !== 2'b10 || commit_valid !== 2'b00) begin nerr++; $display("FAIL wrap_pre got tags=%0d/%0d rdy=%b cv=%b", alloc_tag0, alloc_tag1, rob_rdy, commit_valid); end
    step(2'b11, mk(0, 5'd9, 1, 0), mk(0, 5'd10, 1, 0), 0, 0, 0, 0, 0, 0, 0);
    step(2'b00, z, z, 2'b11, 7, 0, 32'h77, 32'h70, 0, 0);
    nchk++; if (commit_valid !== 2'b11 || commit_rd0 !== 5'd9 || commit_rd1 !== 5'd10 || commit_result1 !== 32'h70) begin nerr++; $display("FAIL wrap_commit got cv=%b rd=%0d/%0d r1=%h", commit_valid, commit_rd0, commit_rd1, commit_result1); end
    idle();
    nchk++; if (alloc_tag0 !== 3'd1) begin nerr++; $display("FAIL wrap_tail got=%0d exp=1", alloc_tag0); end
    step(2'b01, mk(0, 5'd11, 1, 0), z, 0, 0, 0, 0, 0, 0, 0);
    step(2'b00, z, z, 2'b01, 1, 0, 32'hAB, 0, 0, 0);
    nchk++; if (commit_valid !== 2'b01 || commit_rd0 !== 5'd11 || commit_result0 !== 32'hAB) begin nerr++; $display("FAIL wrap_head got cv=%b rd=%0d r=%h", commit_valid, commit_rd0, commit_result0); end
    idle();
  endtask

  task automatic test_random();
    logic [1:0] we, cv, ex;
    int t0, t1, f;
    logic fl;
    rob_entry_t a, b;
    for (int c = 0; c < 600; c++) begin
      nchk++; if (rob_rdy !== e_rdy) begin nerr++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, rob_rdy, e_rdy); end
      nchk++; if (alloc_tag0 !== TW'(mtail) || alloc_tag1 !== TW'((mtail + 1) % D)) begin nerr++; $display("FAIL rnd_tag c=%0d got=%0d exp=%0d", c, alloc_tag0, mtail); end
      nchk++; if (commit_valid !== e_cv || exc_valid !== e_exc) begin nerr++; $display("FAIL rnd_cv c=%0d got=%b/%b exp=%b/%b", c, commit_valid, exc_valid, e_cv, e_exc); end
      if (e_exc) begin
        nchk++; if (exc_pc !== mq[0].pc) begin nerr++; $display("FAIL rnd_excpc c=%0d got=%h exp=%h", c, exc_pc, mq[0].pc); end
      end
      if (e_cv[0]) begin
        nchk++; if (commit_rd0 !== mq[0].rd || commit_result0 !== mq[0].res || commit_store[0] !== mq[0].st || commit_has_rd[0] !== mq[0].hrd) begin nerr++; $display("FAIL rnd_c0 c=%0d got rd=%0d r=%h exp rd=%0d r=%h", c, commit_rd0, commit_result0, mq[0].rd, mq[0].res); end
      end
      if (e_cv[1]) begin
        nchk++; if (commit_rd1 !== mq[1].rd || commit_result1 !== mq[1].res || commit_store[1] !== mq[1].st || commit_has_rd[1] !== mq[1].hrd) begin nerr++; $display("FAIL rnd_c1 c=%0d got rd=%0d r=%h exp rd=%0d r=%h", c, commit_rd1, commit_result1, mq[1].rd, mq[1].res); end
      end
      fl = e_exc ? 1'($urandom % 2) : ($urandom % 100 == 0);
      f  = D - mq.size();
      we = 2'($urandom);
      if (f == 0) we = 2'b00;
      else if (f == 1 && we == 2'b11) we = ($urandom % 2) ? 2'b01 : 2'b10;
      a = mk($urandom, 5'($urandom), 1'($urandom), ($urandom % 4) == 0);
      b = mk($urandom, 5'($urandom), 1'($urandom), ($urandom % 4) == 0);
      cv = 2'($urandom);
      t0 = (mq.size() > 0 && $urandom % 10 < 7) ? mq[$urandom_range(0, mq.size()-1)].tag : int'($urandom % D);
      t1 = (mq.size() > 0 && $urandom % 10 < 7) ? mq[$urandom_range(0, mq.size()-1)].tag : int'($urandom % D);
      ex = {($urandom % 12) == 0, ($urandom % 12) == 0};
      step(we, a, b, cv, t0, t1, $urandom, $urandom, ex, fl);
    end
  endtask

  initial begin
    nerr = 0; nchk = 0;
    test_reset();
    model_eval();
    test_fill();
    test_ooo_commit();
    test_stores();
    test_exception();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
